dbus_cbus_bridge: RTL

- Single-outstanding, uncached bridge that sits directly downstream of the data-bus request producer (CPU memory stage, via dbus_req_t/dbus_resp_t).
- Converts each dbus request into one single-beat cbus_req_t transaction toward the AXI-side crossbar and returns the result as a dbus_resp_t.
- Also performs the alignment check and a bus watchdog, and reports faults through error_t.
- Used for uncached MMIO regions and as the cache-bypass path.

---
 rtl/dbus_cbus_bridge.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/dbus_cbus_bridge.sv
// Uncached dbus-to-cbus bridge: one outstanding request, single-beat cbus
// transactions, alignment check and a bus watchdog reported through error_t.

package dbus_cbus_bridge_pkg;
  typedef logic [2:0] msize_t;
  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  typedef logic [7:0] mlen_t;
  localparam mlen_t MLEN1 = 8'd0;

  typedef logic [1:0] axi_burst_type_t;
  localparam axi_burst_type_t AXI_BURST_FIXED = 2'b00;

  typedef logic [2:0] error_t;
  localparam error_t NOERROR = 3'd0;
  localparam error_t EFETCH  = 3'd1;
  localparam error_t ELOAD   = 3'd2;
  localparam error_t ESTORE  = 3'd3;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    logic [63:0]     addr;
    logic [7:0]      strobe;
    logic [63:0]     data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module dbus_cbus_bridge
  import dbus_cbus_bridge_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [139:0] dreq,
  output logic [65:0]  dresp,
  output logic [150:0] creq,
  input  logic [65:0]  cresp,
  output logic [2:0]   err
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state_q, state_d;
  dbus_req_t  req;
  cbus_resp_t rsp;
  cbus_req_t  creq_s;
  dbus_resp_t dresp_s;
  error_t     err_s;

  logic [63:0]      addr_q;
  msize_t           size_q;
  logic [7:0]       strobe_q;
  logic [63:0]      wdata_q;
  logic             is_write_q;
  logic [63:0]      rdata_q;
  error_t           err_q;
  logic [CNT_W-1:0] cnt_q;

  logic misalign;
  logic complete;
  logic expire;

  assign req   = dreq;
  assign rsp   = cresp;
  assign creq  = creq_s;
  assign dresp = dresp_s;
  assign err   = err_s;

  function automatic logic is_misaligned(input msize_t size, input logic [2:0] lsb);
    logic bad;
    bad = 1'b0;
    if (size == MSIZE2 && lsb[0] != 1'b0)      bad = 1'b1;
    if (size == MSIZE4 && lsb[1:0] != 2'b00)   bad = 1'b1;
    if (size == MSIZE8 && lsb[2:0] != 3'b000)  bad = 1'b1;
    return bad;
  endfunction

  assign misalign = is_misaligned(req.size, req.addr[2:0]);
  assign complete = rsp.ready & rsp.last;
  assign expire   = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and registered-field outputs toward both buses.
  always_comb begin
    state_d          = state_q;
    creq_s           = '0;
    creq_s.is_write  = is_write_q;
    creq_s.size      = size_q;
    creq_s.addr      = addr_q;
    creq_s.strobe    = strobe_q;
    creq_s.data      = wdata_q;
    creq_s.len       = MLEN1;
    creq_s.burst     = AXI_BURST_FIXED;
    dresp_s          = '0;
    err_s            = NOERROR;
    unique case (state_q)
      IDLE: begin
        if (req.valid) state_d = misalign ? DONE : BUSY;
      end
      BUSY: begin
        creq_s.valid = 1'b1;
        if (complete || expire) state_d = DONE;
      end
      DONE: begin
        dresp_s.addr_ok = 1'b1;
        dresp_s.data_ok = 1'b1;
        dresp_s.data    = rdata_q;
        err_s           = err_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, response capture and saturating watchdog counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      size_q     <= '0;
      strobe_q   <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      rdata_q    <= '0;
      err_q      <= NOERROR;
      cnt_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req.valid) begin
            if (misalign) begin
              rdata_q <= '0;
              err_q   <= (|req.strobe) ? ESTORE : ELOAD;
            end else begin
              addr_q     <= req.addr;
              size_q     <= req.size;
              strobe_q   <= req.strobe;
              wdata_q    <= req.data;
              is_write_q <= |req.strobe;
              cnt_q      <= '0;
            end
          end
        end
        BUSY: begin
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
          if (complete) begin
            rdata_q <= rsp.data;
            err_q   <= NOERROR;
          end else if (expire) begin
            rdata_q <= '0;
            err_q   <= is_write_q ? ESTORE : ELOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
